// File: rtl/interface_wheel_step_gen.sv
// Step/direction pulse burst generator: emits count CW or CCW step pulses spaced
// by max(period, MIN_PERIOD) clocks and tracks the net position.
module interface_wheel_step_gen #(
    parameter int N          = 8,
    parameter int MIN_PERIOD = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] count,
    input  logic         dir,
    input  logic [N-1:0] period,
    input  logic         abort,
    output logic         CW,
    output logic         CCW,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] remaining,
    output logic [N-1:0] pos
);

    typedef enum logic [1:0] {IDLE, STEP, WAIT, FIN} state_t;

    localparam logic [N-1:0] MIN_P = N'(MIN_PERIOD);

    state_t       r_state;
    logic         r_dir;
    logic [N-1:0] r_period;
    logic [N-1:0] r_wait;
    logic [N-1:0] r_rem;
    logic [N-1:0] r_pos;
    logic         r_cw;
    logic         r_ccw;
    logic         r_busy;
    logic         r_done;

    logic [N-1:0] w_period;
    logic [N-1:0] w_rem_dec;
    logic [N-1:0] w_pos_step;

    assign w_period   = (period < MIN_P) ? MIN_P : period;
    assign w_rem_dec  = r_rem - N'(1);
    assign w_pos_step = r_dir ? (r_pos - N'(1)) : (r_pos + N'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_dir    <= 1'b0;
            r_period <= '0;
            r_wait   <= '0;
            r_rem    <= '0;
            r_pos    <= '0;
            r_cw     <= 1'b0;
            r_ccw    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cw   <= 1'b0;
            r_ccw  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (start && (count != '0)) begin
                        r_dir    <= dir;
                        r_period <= w_period;
                        r_rem    <= count;
                        r_cw     <= ~dir;
                        r_ccw    <= dir;
                        r_busy   <= 1'b1;
                        r_state  <= STEP;
                    end else if (start) begin
                        r_rem   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                STEP: begin
                    // The pulse of this cycle is counted even when aborted.
                    r_rem <= w_rem_dec;
                    r_pos <= w_pos_step;
                    if (abort || (w_rem_dec == '0)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else if (r_period == N'(1)) begin
                        r_cw    <= ~r_dir;
                        r_ccw   <= r_dir;
                        r_state <= STEP;
                    end else begin
                        r_wait  <= r_period - N'(2);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else if (r_wait == '0) begin
                        r_cw    <= ~r_dir;
                        r_ccw   <= r_dir;
                        r_state <= STEP;
                    end else begin
                        r_wait <= r_wait - N'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign CW        = r_cw;
    assign CCW       = r_ccw;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_rem;
    assign pos       = r_pos;

endmodule
